// File: rtl/alu_control_if.sv
// Decode request/response bundle between main control and the ALU select register.
interface alu_control_if;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alu_ctrl;

  modport master (output ALUOp, funct3, funct7, input  alu_ctrl);
  modport slave  (input  ALUOp, funct3, funct7, output alu_ctrl);
endinterface

// File: rtl/alu_control.sv
// ALUOp/funct3/funct7 decode into the 4-bit ALU select, registered for the EX stage.
module alu_control (
  input  logic           clk,
  input  logic           rst_n,
  alu_control_if.slave   bus
);
  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  alu_op_e dec;
  logic    f7_alt;
  logic    f7_lsb;

  assign f7_alt = bus.funct7[5];
  assign f7_lsb = bus.funct7[0];

  always_comb begin
    dec = OP_ADD;
    unique case (bus.ALUOp)
      // R-type uses the team funct3 map, not the standard RV one
      2'b00: begin
        case (bus.funct3)
          3'b001:  dec = f7_alt ? OP_SUB  : OP_ADD;
          3'b000:  dec = OP_AND;
          3'b111:  dec = OP_OR;
          3'b101:  dec = OP_XOR;
          3'b010:  dec = OP_SLL;
          3'b110:  dec = f7_alt ? OP_SRA  : OP_SRL;
          3'b100:  dec = f7_lsb ? OP_SLTU : OP_SLT;
          default: dec = OP_ADD;
        endcase
      end
      2'b01: begin
        case (bus.funct3)
          3'b000:  dec = OP_ADD;
          3'b001:  dec = OP_SLL;
          3'b010:  dec = OP_SLT;
          3'b011:  dec = OP_SLTU;
          3'b100:  dec = OP_XOR;
          3'b101:  dec = f7_alt ? OP_SRA : OP_SRL;
          3'b110:  dec = OP_OR;
          default: dec = OP_AND;
        endcase
      end
      2'b10:   dec = OP_ADD;
      default: dec = OP_SUB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.alu_ctrl <= OP_ADD;
    else        bus.alu_ctrl <= dec;
  end
endmodule

// File: tb/tb_alu_control.sv
// Directed plus random checks of the registered ALU select decode.
module tb_alu_control;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  alu_control_if bus ();

  alu_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Base op per funct3; a set modifier bit selects the next encoding up
  // (ADD->SUB, SRL->SRA, SLT->SLTU).
  logic [3:0] r_base [8] = '{4'h2, 4'h0, 4'h5, 4'h0, 4'h8, 4'h4, 4'h6, 4'h3};
  logic [3:0] i_base [8] = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};

  function automatic logic [3:0] ref_op(input logic [1:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic [3:0] r;
    r = 4'h0;
    if (op == 2'b00) begin
      r = r_base[f3];
      if ((f3 == 3'b001 || f3 == 3'b110) && f7[5]) r = r + 4'h1;
      if (f3 == 3'b100 && f7[0]) r = r + 4'h1;
    end else if (op == 2'b01) begin
      r = i_base[f3];
      if (f3 == 3'b101 && f7[5]) r = r + 4'h1;
    end else if (op == 2'b10) begin
      r = 4'h0;
    end else begin
      r = 4'h1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [3:0] exp);
    n_cmp++;
    assert (bus.alu_ctrl === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, bus.alu_ctrl, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.ALUOp  = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  // Drive at negedge, sample 1 time unit after the following posedge.
  task automatic step(input string tag, input logic [1:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [3:0] exp);
    @(negedge clk);
    drive(op, f3, f7);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  typedef struct {
    string      tag;
    logic [1:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] exp;
  } vec_t;

  vec_t dir [12] = '{
    '{"r_add",  2'b00, 3'b001, 7'b0010000, 4'b0000},
    '{"r_sub",  2'b00, 3'b001, 7'b0110000, 4'b0001},
    '{"r_and",  2'b00, 3'b000, 7'b0010000, 4'b0010},
    '{"r_or",   2'b00, 3'b111, 7'b0010000, 4'b0011},
    '{"r_xor",  2'b00, 3'b101, 7'b0010000, 4'b0100},
    '{"r_sltu", 2'b00, 3'b100, 7'b0000001, 4'b1001},
    '{"r_srl",  2'b00, 3'b110, 7'b0010000, 4'b0110},
    '{"r_sra",  2'b00, 3'b110, 7'b0110000, 4'b0111},
    '{"i_add",  2'b01, 3'b000, 7'b0000000, 4'b0000},
    '{"i_or",   2'b01, 3'b110, 7'b0000000, 4'b0011},
    '{"i_and",  2'b01, 3'b111, 7'b0000000, 4'b0010},
    '{"i_sra",  2'b01, 3'b101, 7'b0100000, 4'b0111}
  };

  initial begin
    logic [1:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(2'b11, 3'b000, 7'b0000000);

    // Held in reset: edges and input changes must not load anything
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(2'($urandom), 3'($urandom), 7'($urandom));
      @(posedge clk);
      #1;
      check("rst_hold", 4'b0000);
    end

    @(negedge clk);
    rst_n = 1'b1;
    step("rst_release_branch", 2'b11, 3'b010, 7'b1010101, 4'b0001);

    foreach (dir[i]) step(dir[i].tag, dir[i].op, dir[i].f3, dir[i].f7, dir[i].exp);

    for (int i = 0; i < 16; i++)
      step("ldst_rand", 2'b10, 3'($urandom), 7'($urandom), 4'b0000);
    for (int i = 0; i < 16; i++)
      step("branch_rand", 2'b11, 3'($urandom), 7'($urandom), 4'b0001);

    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom);
      f3 = 3'($urandom);
      f7 = 7'($urandom);
      step("rand_model", op, f3, f7, ref_op(op, f3, f7));
    end

    // Mid-cycle input change is invisible until the next rising edge
    step("lat_before", 2'b01, 3'b100, 7'b0000000, 4'b0100);
    #2;
    drive(2'b01, 3'b001, 7'b0000000);
    #1;
    check("lat_hold", 4'b0100);
    @(negedge clk);
    check("lat_hold_neg", 4'b0100);
    @(posedge clk);
    #1;
    check("lat_after", 4'b0101);

    // Async reset pulse between edges while holding SRA
    step("arst_pre", 2'b00, 3'b110, 7'b0110000, 4'b0111);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_immediate", 4'b0000);
    drive(2'b00, 3'b100, 7'b0000000);
    #1;
    rst_n = 1'b1;
    #1;
    check("arst_still_zero", 4'b0000);
    @(posedge clk);
    #1;
    check("arst_next_edge", 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
